dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, meaning: number of BUSY cycles between request acceptance and response; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder can accept a request.
REQ-006 req_write  input  1  1 = store doubleword, 0 = load doubleword.
REQ-007 req_addr  input  10  byte address into 1 KiB space.
REQ-008 req_wdata  input  64  store data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  initiator consumes the response.
REQ-011 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  request was misaligned (req_addr[2:0] != 0).

Function
REQ-013 Storage SHALL be 128 x 64-bit doublewords, indexed by address bits [9:3].
REQ-014 FSM states SHALL be IDLE, BUSY and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 A handshake occurs on a rising edge with req_valid=1 and req_ready=1.
REQ-017 On a handshake, write, addr and wdata SHALL be latched, the counter SHALL load LATENCY-1, and the FSM SHALL go IDLE->BUSY.
REQ-018 Request inputs SHALL be ignored outside IDLE; changes to them after the handshake SHALL NOT affect the transaction.
REQ-019 In BUSY, if the counter is 0 the access SHALL be performed and the FSM SHALL go to RESP; otherwise the counter SHALL decrement.
REQ-020 Timing: handshake at edge N gives rsp_valid=1 from edge N+LATENCY.
REQ-021 Aligned store: the doubleword SHALL be written on the BUSY->RESP edge; rsp_rdata=0; rsp_err=0.
REQ-022 Aligned load: rsp_rdata SHALL be the stored doubleword, including a store completed by the immediately preceding transaction; rsp_err=0.
REQ-023 Misaligned request: no memory update, rsp_rdata=0, rsp_err=1, same latency as an aligned request.
REQ-024 rsp_rdata and rsp_err SHALL be registered and held stable while rsp_valid=1 and rsp_ready=0.
REQ-025 In RESP with rsp_ready=1, the FSM SHALL go to IDLE on that edge; no new request is accepted in the same cycle.
REQ-026 Maximum throughput is therefore 1 transaction per LATENCY+2 cycles.
REQ-027 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, all storage 0, req_ready=1 after release.
REQ-029 Reset asserted mid-BUSY or mid-RESP SHALL abort the transaction: no store commits and no response is issued.

Structure
REQ-030 Package dmem_pkg SHALL hold the state enum, DATA_W=64, ADDR_W=10, DEPTH=128, and a default latency constant.
REQ-031 Storage SHALL be a sub-module dmem_array with a synchronous write port, a combinational read port and an asynchronous clear; FSM and counter logic SHALL stay in dmem_responder.

Verification
REQ-032 Reset, then store addr=0x008 data=0xDEADBEEF_CAFEF00D; load addr=0x008 -> rdata=0xDEADBEEF_CAFEF00D, err=0.
REQ-033 LATENCY=3, handshake at cycle 10 -> rsp_valid rises at cycle 13, and req_ready=0 during cycles 10-13.
REQ-034 Load addr=0x00C -> err=1, rdata=0; a following load of 0x008 returns the unchanged prior value.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-036 Assert reset during BUSY of store 0x3F8 <- 0x1; a later load of 0x3F8 returns 0, and rsp_valid=0 throughout reset.
REQ-037 Store 0x3F8 (top index 127) then load 0x000 and 0x3F8 -> 0 and the stored value respectively, with no aliasing.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the doubleword memory responder.
// Holds the FSM state encoding, bus widths, storage depth and default latency.
package dmem_pkg;
    localparam int DATA_W      = 64;
    localparam int ADDR_W      = 10;
    localparam int DEPTH       = 128;
    localparam int IDX_W       = 7;
    localparam int LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_array.sv
// 128 x 64-bit storage: synchronous write, combinational read, async clear.
// Zero latency read; no backpressure (the caller sequences accesses).
module dmem_array
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a 1 KiB doubleword memory.
// Response LATENCY cycles after handshake; response held until rsp_ready, no new request meanwhile.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              do_access;
    logic              hs;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              aligned;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    assign hs        = (state == IDLE) && req_valid;
    assign aligned   = (addr_q[2:0] == 3'b000);
    assign mem_we    = do_access && wr_q && aligned;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once so later input wiggles cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (hs) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (do_access) begin
            rdata_q <= (!wr_q && aligned) ? mem_rd : '0;
            err_q   <= !aligned;
        end
    end

    dmem_array u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we),
        .idx     (addr_q[9:3]),
        .wr_data (wdata_q),
        .rd_data (mem_rd)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with LATENCY=3.
module tb_dmem_responder;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mdl [128];
    int          n_tests = 0;
    int          n_fail  = 0;

    dmem_responder #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Response consumption happens on the edge following this sample.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("rsp_rdata", rsp_rdata, x.d);
                check("rsp_err", {63'd0, rsp_err}, {63'd0, x.e});
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 128; i++) mdl[i] = '0;
    endtask

    task automatic xact(input logic wr, input logic [9:0] a, input logic [63:0] d, input int hold);
        exp_t        x;
        int          n;
        logic [63:0] hd;
        logic        he;
        @(posedge clk); #1;
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        x.e = (a[2:0] != 3'b000);
        x.d = (!wr && !x.e) ? mdl[a[9:3]] : 64'd0;
        if (wr && !x.e) mdl[a[9:3]] = d;
        sb.push_back(x);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = ~a;
        req_wdata = ~d;
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (req_ready) check("req_ready_busy", 64'd1, 64'd0);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(LAT));
        check("req_ready_resp", {63'd0, req_ready}, 64'd0);
        if (hold > 0) begin
            hd = rsp_rdata;
            he = rsp_err;
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", {63'd0, rsp_valid}, 64'd1);
                check("hold_rdata", rsp_rdata, hd);
                check("hold_err", {63'd0, rsp_err}, {63'd0, he});
                check("hold_req_ready", {63'd0, req_ready}, 64'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_done", {63'd0, rsp_valid}, 64'd0);
        check("req_ready_after", {63'd0, req_ready}, 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        model_clear();
        #12;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_err", {63'd0, rsp_err}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);

        xact(1'b1, 10'h008, 64'hDEADBEEF_CAFEF00D, 0);
        xact(1'b0, 10'h008, 64'h0, 0);
        xact(1'b0, 10'h00C, 64'h0, 0);
        xact(1'b0, 10'h008, 64'h0, 0);
        xact(1'b0, 10'h008, 64'h0, 5);
        xact(1'b1, 10'h00A, 64'h1111_2222_3333_4444, 0);
        xact(1'b0, 10'h008, 64'h0, 0);
        xact(1'b1, 10'h3F8, 64'hA5A5_5A5A_0F0F_F0F0, 0);
        xact(1'b0, 10'h000, 64'h0, 0);
        xact(1'b0, 10'h3F8, 64'h0, 0);
        for (int i = 0; i < 6; i++) begin
            logic [9:0] ra;
            ra = 10'($urandom_range(0, 1023));
            if (i < 3) ra[2:0] = 3'b000;
            xact(1'(i % 2 == 0), ra, {$urandom, $urandom}, 0);
            xact(1'b0, ra, 64'h0, 0);
        end

        // Abort a store mid-BUSY; reset wipes storage so the model clears too.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 10'h3F8;
        req_wdata = 64'h1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        xact(1'b0, 10'h3F8, 64'h0, 0);
        xact(1'b0, 10'h008, 64'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
